// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package bcd2bin_seq_pkg;

    // Controller state encoding, shared with the other BCD/binary converter FSMs.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Reverse double-dabble corrects each digit by subtracting 3. The
    // subtraction is done as a two's-complement add, so keep the negated form.
    localparam logic [3:0] DIGIT_ADJ     = 4'd3;
    localparam logic [3:0] DIGIT_ADJ_NEG = ~DIGIT_ADJ + 4'd1;

    // Largest decimal value representable with n_digits BCD digits.
    function automatic longint bcd_max(input int n_digits);
        longint v;
        v = 1;
        for (int i = 0; i < n_digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_digit_adj.sv
// Per-digit correction for reverse double-dabble: if digit >= 8 then digit - 3.
// Latency: combinational.
// Backpressure: none.
//   d : 4-bit digit after the shift
//   q : corrected digit
module bcd_digit_adj
    import bcd2bin_seq_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Digits >= 8 have bit 3 set; they can never underflow when reduced by 3.
    assign q = d[3] ? (d + DIGIT_ADJ_NEG) : d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to unsigned binary converter, one shift per clock.
// Latency: start edge in cycle 0 -> out_DONE in cycle 4*N_DIGITS+1; bad digit -> cycle 1.
// Backpressure: in_INIT is ignored while busy; no queuing, caller retries in IDLE.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   in_BCD   : packed BCD input, units digit in [3:0], sampled on accepted start
//   in_INIT  : start request, honoured only in IDLE
//   out_BIN  : converted value, held until the next DONE (0 on error)
//   out_BUSY : high from accepted start through the DONE cycle
//   out_DONE : one-cycle pulse, out_BIN/out_ERR valid in that cycle
//   out_ERR  : last request contained a digit > 9, held until the next DONE
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int BIN_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] in_BCD,
    input  logic                  in_INIT,
    output logic [BIN_W-1:0]      out_BIN,
    output logic                  out_BUSY,
    output logic                  out_DONE,
    output logic                  out_ERR
);

    localparam int W     = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    if (N_DIGITS < 1) begin : g_digits_check
        $error("bcd2bin_seq: N_DIGITS must be at least 1");
    end
    if (bcd_max(N_DIGITS) >= (longint'(1) << BIN_W)) begin : g_width_check
        $error("bcd2bin_seq: BIN_W too narrow for the largest BCD value");
    end

    state_t             state;
    state_t             state_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [W-1:0]       bcd_reg;
    logic [W-1:0]       bin_reg;
    logic [W-1:0]       bcd_shift;
    logic [W-1:0]       bcd_adj;
    logic [W-1:0]       bin_shift;
    logic [BIN_W-1:0]   bin_res;
    logic [CNT_W-1:0]   cnt;
    logic               in_bad;
    logic               last_shift;

    // Any digit above 9 rejects the request without shifting.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (in_BCD[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // {bcd_reg, bin_reg} shifted right by one as a single 2W-bit register.
    assign bcd_shift = {1'b0, bcd_reg[W-1:1]};
    assign bin_shift = {bcd_reg[0], bin_reg[W-1:1]};

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_shift[4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    // The result is captured on the final shift so it is already valid
    // while out_DONE is high. Bits above BIN_W are zero for legal input.
    if (BIN_W < W) begin : g_res_trunc
        logic unused_bin_hi;
        assign bin_res       = bin_shift[BIN_W-1:0];
        assign unused_bin_hi = |bin_shift[W-1:BIN_W];
    end else if (BIN_W == W) begin : g_res_exact
        assign bin_res = bin_shift;
    end else begin : g_res_ext
        assign bin_res = {{(BIN_W-W){1'b0}}, bin_shift};
    end

    assign last_shift = (cnt == CNT_W'(W - 1));

    // State register; BUSY/DONE are registered from the next-state decode so
    // they change only on the clock and line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            out_BUSY <= 1'b0;
            out_DONE <= 1'b0;
        end else begin
            state    <= state_nxt;
            out_BUSY <= busy_nxt;
            out_DONE <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_INIT) begin
                    state_nxt = in_bad ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_shift) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            out_BIN <= '0;
            out_ERR <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_INIT) begin
                        bcd_reg <= in_BCD;
                        bin_reg <= '0;
                        cnt     <= '0;
                        if (in_bad) begin
                            out_BIN <= '0;
                            out_ERR <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= bin_shift;
                    cnt     <= cnt + 1'b1;
                    if (last_shift) begin
                        out_BIN <= bin_res;
                        out_ERR <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

    typedef struct {
        int   bin;
        logic err;
        int   t0;
        int   lat;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          checks;
    int          errors;

    // N=3, BIN_W=10 instance
    logic [11:0] in_bcd3;
    logic        in_init3;
    logic [9:0]  out_bin3;
    logic        out_busy3;
    logic        out_done3;
    logic        out_err3;
    exp_t        q3[$];
    int          done_cnt3;

    // N=2, BIN_W=7 instance
    logic [7:0]  in_bcd2;
    logic        in_init2;
    logic [6:0]  out_bin2;
    logic        out_busy2;
    logic        out_done2;
    logic        out_err2;
    exp_t        q2[$];
    int          done_cnt2;

    bcd2bin_seq #(.N_DIGITS(3), .BIN_W(10)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .in_BCD   (in_bcd3),
        .in_INIT  (in_init3),
        .out_BIN  (out_bin3),
        .out_BUSY (out_busy3),
        .out_DONE (out_done3),
        .out_ERR  (out_err3)
    );

    bcd2bin_seq #(.N_DIGITS(2), .BIN_W(7)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_BCD   (in_bcd2),
        .in_INIT  (in_init2),
        .out_BIN  (out_bin2),
        .out_BUSY (out_busy2),
        .out_DONE (out_done2),
        .out_ERR  (out_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop the expected result whenever a DONE pulse shows up.
    always @(negedge clk) begin
        exp_t e;
        if (out_done3) begin
            done_cnt3++;
            if (q3.size() == 0) begin
                check("dut3 unexpected done", 1, 0);
            end else begin
                e = q3.pop_front();
                check("dut3 bin", int'(out_bin3), e.bin);
                check("dut3 err", int'(out_err3), int'(e.err));
                check("dut3 latency", cyc - e.t0, e.lat);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_done2) begin
            done_cnt2++;
            if (q2.size() == 0) begin
                check("dut2 unexpected done", 1, 0);
            end else begin
                e = q2.pop_front();
                check("dut2 bin", int'(out_bin2), e.bin);
                check("dut2 err", int'(out_err2), int'(e.err));
                check("dut2 latency", cyc - e.t0, e.lat);
            end
        end
    end

    // Issue one request on dut3 at the current negedge (cycle 0) and return
    // at the first IDLE cycle after DONE.
    task automatic run3(input logic [11:0] bcd, input int exp_bin, input logic exp_err,
                        input bit chk_busy);
        int lat;
        lat = exp_err ? 1 : 13;
        in_bcd3  = bcd;
        in_init3 = 1'b1;
        q3.push_back('{bin: exp_bin, err: exp_err, t0: cyc, lat: lat});
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) in_init3 = 1'b0;
            if (chk_busy) check($sformatf("dut3 busy c%0d", k), int'(out_busy3), (k <= lat) ? 1 : 0);
        end
    endtask

    task automatic run2(input logic [7:0] bcd, input int exp_bin, input logic exp_err);
        int lat;
        lat = exp_err ? 1 : 9;
        in_bcd2  = bcd;
        in_init2 = 1'b1;
        q2.push_back('{bin: exp_bin, err: exp_err, t0: cyc, lat: lat});
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) in_init2 = 1'b0;
        end
    endtask

    initial begin
        int t0;
        int dc;
        logic [7:0] v2;
        checks    = 0;
        errors    = 0;
        done_cnt3 = 0;
        done_cnt2 = 0;
        rst       = 1'b0;
        in_bcd3   = '0;
        in_init3  = 1'b0;
        in_bcd2   = '0;
        in_init2  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset bin3", int'(out_bin3), 0);
        check("reset busy3", int'(out_busy3), 0);
        check("reset done3", int'(out_done3), 0);
        check("reset err3", int'(out_err3), 0);
        check("reset bin2", int'(out_bin2), 0);
        check("reset busy2", int'(out_busy2), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic conversions, busy window checked on two of them
        run3(12'h999, 999, 1'b0, 1'b1);
        run3(12'h000, 0, 1'b0, 1'b1);
        run3(12'h255, 255, 1'b0, 1'b1);

        // Invalid digit, then recovery
        run3(12'h1A3, 0, 1'b1, 1'b1);
        run3(12'h042, 42, 1'b0, 1'b0);
        run3(12'h80F, 0, 1'b1, 1'b0);
        run3(12'h128, 128, 1'b0, 1'b0);

        // Back-to-back with INIT held high: single IDLE cycle between runs
        in_bcd3  = 12'h613;
        in_init3 = 1'b1;
        q3.push_back('{bin: 613, err: 1'b0, t0: cyc, lat: 13});
        repeat (13) @(negedge clk);
        in_bcd3 = 12'h087;
        @(negedge clk);
        q3.push_back('{bin: 87, err: 1'b0, t0: cyc, lat: 13});
        @(negedge clk);
        in_init3 = 1'b0;
        repeat (13) @(negedge clk);

        // Second start while busy is ignored; in_BCD changes are not sampled
        dc       = done_cnt3;
        in_bcd3  = 12'h500;
        in_init3 = 1'b1;
        t0       = cyc;
        q3.push_back('{bin: 500, err: 1'b0, t0: t0, lat: 13});
        @(negedge clk);
        in_init3 = 1'b0;
        repeat (4) @(negedge clk);
        in_bcd3  = 12'h111;
        in_init3 = 1'b1;
        @(negedge clk);
        in_init3 = 1'b0;
        repeat (8) @(negedge clk);
        check("ignored start done count", done_cnt3 - dc, 1);

        // Reset mid-conversion aborts without a DONE pulse
        in_bcd3  = 12'h777;
        in_init3 = 1'b1;
        @(negedge clk);
        in_init3 = 1'b0;
        repeat (5) @(negedge clk);
        dc = done_cnt3;
        #2 rst = 1'b0;
        #1;
        check("abort bin3", int'(out_bin3), 0);
        check("abort busy3", int'(out_busy3), 0);
        check("abort done3", int'(out_done3), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("abort no done", done_cnt3 - dc, 0);
        run3(12'h321, 321, 1'b0, 1'b0);

        // Two-digit sweep 00..99 plus one invalid code
        for (int d = 0; d < 100; d++) begin
            v2 = {4'(d / 10), 4'(d % 10)};
            run2(v2, d, 1'b0);
        end
        run2(8'h9C, 0, 1'b1);
        run2(8'h73, 73, 1'b0);

        repeat (3) @(negedge clk);
        check("dut3 pending results", q3.size(), 0);
        check("dut2 pending results", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
